// File: rtl/aes_pkg.sv
// Shared constants, FSM encoding and GF(2^8) helpers for the AES inverse cipher.
package aes_pkg;

    localparam int NR_128 = 10;
    localparam int NR_256 = 14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_MAIN = 2'd2
    } dec_state_e;

    // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul09(input logic [7:0] b);
        logic [7:0] b2, b4, b8;
        b2 = xtime(b);
        b4 = xtime(b2);
        b8 = xtime(b4);
        return b8 ^ b;
    endfunction

    function automatic logic [7:0] mul0b(input logic [7:0] b);
        logic [7:0] b2, b4, b8;
        b2 = xtime(b);
        b4 = xtime(b2);
        b8 = xtime(b4);
        return b8 ^ b2 ^ b;
    endfunction

    function automatic logic [7:0] mul0d(input logic [7:0] b);
        logic [7:0] b2, b4, b8;
        b2 = xtime(b);
        b4 = xtime(b2);
        b8 = xtime(b4);
        return b8 ^ b4 ^ b;
    endfunction

    function automatic logic [7:0] mul0e(input logic [7:0] b);
        logic [7:0] b2, b4, b8;
        b2 = xtime(b);
        b4 = xtime(b2);
        b8 = xtime(b4);
        return b8 ^ b4 ^ b2;
    endfunction

    // One column: first byte is row 0.
    function automatic logic [31:0] inv_mixcolumn(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3),
                mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3),
                mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3),
                mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3)};
    endfunction

    function automatic logic [127:0] inv_mixcolumns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127-32*c -: 32] = inv_mixcolumn(s[127-32*c -: 32]);
        end
        return o;
    endfunction

    // Byte (row r, column c) lives at index 4c+r, counted from the MSB.
    // Row r rotates right by r columns.
    function automatic logic [127:0] inv_shiftrows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Four parallel inverse S-box byte lookups on a 32-bit word.
module aes_inv_sbox (
    input  logic [31:0] in_word,
    output logic [31:0] out_word
);

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign out_word = {INV_SBOX[in_word[31:24]], INV_SBOX[in_word[23:16]],
                       INV_SBOX[in_word[15:8]],  INV_SBOX[in_word[7:0]]};

endmodule

// File: rtl/aes_decipher.sv
// Iterative AES-128/256 inverse cipher, one round per cycle.
// Build option AES_DEC_SHARED_SBOX_EN: a single shared inverse S-box word,
// each round spread over four sub-cycles (one column per sub-cycle).
//
// state    | meaning
// ST_IDLE  | ready, result held in state register, waiting for next
// ST_INIT  | initial AddRoundKey with key Nr
// ST_MAIN  | inverse rounds Nr-1 .. 0, last round skips InvMixColumns
module aes_decipher
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         next,
    input  logic         keylen,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready
);

    dec_state_e   fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] sr;
    logic [127:0] sub_bytes;
    logic [127:0] t;
    logic         last_sub;

    assign sr = inv_shiftrows(state_q);

`ifdef AES_DEC_SHARED_SBOX_EN
    logic [1:0]  sub_q, sub_d;
    logic [95:0] temp_q, temp_d;
    logic [31:0] sbox_in, sbox_out;

    // Select the column of InvShiftRows(state) handled in this sub-cycle.
    always_comb begin
        case (sub_q)
            2'd0:    sbox_in = sr[127:96];
            2'd1:    sbox_in = sr[95:64];
            2'd2:    sbox_in = sr[63:32];
            default: sbox_in = sr[31:0];
        endcase
    end

    aes_inv_sbox u_sbox (
        .in_word  (sbox_in),
        .out_word (sbox_out)
    );

    // Collect columns 0..2; column 3 comes straight from the S-box.
    always_comb begin
        sub_d  = 2'd0;
        temp_d = temp_q;
        if (fsm_q == ST_MAIN) begin
            sub_d = sub_q + 2'd1;
            case (sub_q)
                2'd0:    temp_d[95:64] = sbox_out;
                2'd1:    temp_d[63:32] = sbox_out;
                2'd2:    temp_d[31:0]  = sbox_out;
                default: ;
            endcase
        end
    end

    // Sub-cycle counter and partial-round buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_q  <= 2'd0;
            temp_q <= '0;
        end else begin
            sub_q  <= sub_d;
            temp_q <= temp_d;
        end
    end

    assign sub_bytes = {temp_q, sbox_out};
    assign last_sub  = (sub_q == 2'd3);
`else
    for (genvar c = 0; c < 4; c++) begin : g_sbox
        aes_inv_sbox u_sbox (
            .in_word  (sr[127-32*c -: 32]),
            .out_word (sub_bytes[127-32*c -: 32])
        );
    end

    assign last_sub = 1'b1;
`endif

    assign t = sub_bytes ^ round_key;

    // Next-state, datapath and round-index sequencing.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        round_d = round_q;
        case (fsm_q)
            ST_IDLE: begin
                if (next) begin
                    state_d = block;
                    round_d = keylen ? 4'(NR_256) : 4'(NR_128);
                    fsm_d   = ST_INIT;
                end
            end
            ST_INIT: begin
                state_d = state_q ^ round_key;
                round_d = round_q - 4'd1;
                fsm_d   = ST_MAIN;
            end
            ST_MAIN: begin
                if (last_sub) begin
                    if (round_q != 4'd0) begin
                        state_d = inv_mixcolumns(t);
                        round_d = round_q - 4'd1;
                    end else begin
                        state_d = t;
                        fsm_d   = ST_IDLE;
                    end
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    // State register, round index and FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            round_q <= 4'd0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            round_q <= round_d;
        end
    end

    assign ready     = (fsm_q == ST_IDLE);
    assign round     = round_q;
    assign new_block = state_q;

endmodule

// File: doc/aes_decipher.md
# aes_decipher

Iterative AES inverse-cipher datapath, the decrypt-direction counterpart of the encipher block inside the AES core. It processes one 128-bit block per `next` request, supporting AES-128 (10 rounds) or AES-256 (14 rounds). It requests round keys by round index from the core's key store and returns the plaintext on `new_block`, with `ready` as the completion handshake.

## Interface
Parameters:
- none. Round counts and encodings are constants in the shared package.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `next`  in  1  start request; sampled only while `ready`=1.
- `keylen`  in  1  0 = AES-128 (Nr=10), 1 = AES-256 (Nr=14); sampled with `next`.
- `round`  out  4  round-key index currently requested; registered.
- `round_key`  in  128  key for index `round`, combinationally valid in the same cycle.
- `block`  in  128  ciphertext; sampled with `next`.
- `new_block`  out  128  plaintext; valid while `ready`=1 after a completed operation.
- `ready`  out  1  idle / result valid.

## Operation
FSM states: IDLE, INIT, MAIN.
- **IDLE:** `ready`=1.
  - On `next`=1:
    - latch `keylen` → Nr;
    - latch `block` into the state register;
    - set `round` to Nr;
    - go to INIT.
- **INIT:** state ← state ^ `round_key` (key Nr); `round` ← Nr−1; go to MAIN.
- **MAIN, at round r:**
  - t = InvSubBytes(InvShiftRows(state)) ^ `round_key`.
  - If r>0: state ← InvMixColumns(t); `round` ← r−1.
  - If r=0: state ← t; go to IDLE; `ready` ← 1.
- **Byte order:** byte 0 = bits [127:120], column-major per FIPS-197.
- **InvMixColumns:** GF(2^8) multiplies by 0x0e/0x0b/0x0d/0x09 over polynomial 0x11b, built from xtime chains. No lookup tables.
- **`next` while busy** (`ready`=0): ignored, with no queuing. `block`, `keylen` and `round_key` need not be stable except in the cycles where they are sampled.
- **`next` held high across completion:** starts a new operation on the first cycle `ready`=1. `new_block` from the previous operation is still valid in that cycle.
- **Reset mid-operation:** immediate abort to IDLE; no partial result is preserved.
- **Reset values:**
  - `ready`=1
  - `round`=0
  - `new_block`=0 (state register cleared)
  - FSM=IDLE

## Timing
- `next` is sampled at edge T. `ready` is low from T through T+Nr+1 and returns high after edge T+Nr+1.
- Busy time: 11 cycles for AES-128, 15 cycles for AES-256.
- Round-key request sequence: `round` = Nr in INIT, then Nr−1 … 0 in MAIN, one index per cycle.
- The `round` → `round_key` path is combinational in the key store. There is no added pipeline stage.

## Configuration
- **`AES_DEC_SHARED_SBOX_EN`**
  - **Undefined:** 16 inverse S-boxes (4 × `aes_inv_sbox`); one cycle per round.
  - **Defined:**
    - One `aes_inv_sbox` is shared across columns.
    - Each MAIN round takes 4 sub-cycles, j = 0..3. Sub-cycle j substitutes column j of InvShiftRows(state) into a 96-bit temp.
    - On sub-cycle 3, the round completes exactly as above.
    - `round` is held for all 4 sub-cycles.
    - Busy time is 4·Nr+1 cycles: 41 for AES-128, 57 for AES-256.
  - Results are bit-identical in both builds.

## Structure
- **Package `aes_pkg`:**
  - NR_128=10, NR_256=14.
  - FSM state encoding.
  - GF helper functions: xtime, mul09, mul0b, mul0d, mul0e, inv_mixcolumn(32b).
  - inv_shiftrows(128b).
- **Sub-module `aes_inv_sbox`:**
  - 32-bit in, 32-bit out.
  - Four byte lookups of the 256-entry inverse S-box, purely combinational.
  - Instantiated 4× normally, or 1× under the macro.

## Test plan
- **FIPS-197 C.1, AES-128:**
  - Stimulus: key 000102…0f; `block`=69c4e0d86a7b0430d8cdb78070b4c55a; `next` pulse.
  - Response: `new_block`=00112233445566778899aabbccddeeff when `ready` rises, exactly 11 cycles later.
  - `round` observed as 10,9,…,0.
- **FIPS-197 C.3, AES-256:**
  - Stimulus: key 00…1f; `block`=8ea2b7ca516745bfeafc49904b496089.
  - Response: plaintext 00112233445566778899aabbccddeeff after 15 cycles; `round` runs 14..0.
- **`next` pulses during busy** (every cycle of an AES-128 operation): exactly one operation, same result, no restart.
- **`next` held high continuously** with alternating AES-128/AES-256 vectors: back-to-back results correct, one idle cycle between operations.
- **`rst_n` asserted mid-operation** at round 5: `ready`=1, `round`=0, `new_block`=0 immediately. A following C.1 run then decrypts correctly.
- **Rebuild with `AES_DEC_SHARED_SBOX_EN`:** repeat C.1 and C.3 → same plaintexts with latencies 41 and 57; each `round` value held for 4 cycles.
